serial_tx_arbiter: RTL and testbench
====================================

# serial_tx_arbiter

Round-robin arbiter and sequencer that shares one bit-serial byte transmitter among `N_REQ` requesters, such as the ADC channel sequencer and the status reporter. It accepts a byte from the winning requester and frames it as start bit, 8 data bits MSB first, then stop bit, with each bit held `BIT_CYCLES` clocks. It gates transmission on `dsr`, aborts cleanly if `dsr` drops mid-frame, and returns a one-cycle `ack` to the served requester.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `BIT_CYCLES`, 105, clocks per serial bit (>= 2)
- `clock`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  `N_REQ`  level request; held by requester until its `ack`
- `data_in`  in  `8*N_REQ`  byte of requester i on bits [8i+7:8i]
- `dsr`  in  1  receiver ready; must be 1 to start and throughout a frame
- `ack`  out  `N_REQ`  one-hot, one-cycle pulse on completed frame
- `grant_id`  out  `$clog2(N_REQ)`  index of requester being served or last served
- `busy`  out  1  frame in progress
- `data_out`  out  1  serial line; idles at 1
- `tx_end`  out  1  one-cycle pulse, last cycle of the stop bit
- `error`  out  1  sticky abort flag

## Operation
- Reset values: `data_out`=1; `ack`, `busy`, `tx_end`, `error` = 0; `grant_id`=0; round-robin pointer `last`=N_REQ-1, so requester 0 has priority first; state IDLE.
- States:
  - IDLE: if `|req` and `dsr`=1, pick the first set `req` searching from `last`+1 with wrap-around. Latch its byte, set `grant_id`, `busy`=1, `error`=0, and go to SEND. If `req` is set but `dsr`=0, stay in IDLE with no error.
  - SEND: the serializer shifts out 10 bits: 0, d7..d0, 1. After the stop bit's final cycle, go to IDLE.
  - ABORT: one cycle with `data_out`=1, `busy`=0, then IDLE.
- Completion: during the stop bit's final cycle, `tx_end`=1 and `ack[grant_id]`=1. `last` updates to `grant_id` only on completion.
- Abort: `dsr` sampled 0 in any SEND cycle → next cycle `data_out`=1, `error`=1, no `ack`/`tx_end`, state ABORT. `last` is unchanged, so the same requester is re-granted first once `dsr` returns.
- `req` deasserted mid-frame: ignored; the frame completes and `ack` still pulses.
- A `req` rising during SEND waits for IDLE. `data_in` is sampled only at grant.
- `error` clears only on the next accepted grant or on reset.

## Timing
- Grant edge E: `data_out`=0 (start bit) from E until E+`BIT_CYCLES`. Bit k (k=0..9) occupies cycles [k·BC, (k+1)·BC) after E. All outputs are registered.
- `tx_end`/`ack`/`busy` fall edge: `tx_end` and `ack` are high in cycle 10·BC-1 after E. `busy` falls at edge E+10·BC.
- Minimum frame-to-frame spacing: 10·BC+1 cycles, with one IDLE cycle where `data_out`=1.
- Per-bit counter is `$clog2(BIT_CYCLES)` bits and wraps BC-1 → 0. The bit index is a 4-bit count, 0..9.
- Asynchronous reset mid-frame immediately forces all reset values. No `ack` is issued.

## Structure
- Package `serial_tx_pkg`: state enum (IDLE, SEND, ABORT), `FRAME_BITS`=10, `START_LVL`=0, `STOP_LVL`=1, `IDLE_LVL`=1.
- Sub-module `tx_frame_serializer` holds the shift register, bit/cycle counters, `data_out` and `tx_end`.
  - Inputs: `load`, `byte`, `abort`.
- The top level holds the arbiter pointer, FSM, `ack`/`grant_id`/`error` logic.

## Test plan
- Reset: assert `rst_n`=0 → `data_out`=1, `ack`=0, `busy`=0, `tx_end`=0, `error`=0, `grant_id`=0.
- BIT_CYCLES=4, `req`=0001, byte0=0xA5, `dsr`=1 → `data_out` 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; `tx_end` and `ack`=0001 in cycle 39; `busy` low at 40.
- All `req`=1111 held → grant order 0,1,2,3,0, each frame followed by exactly one idle cycle.
- `req`=0100 with `dsr`=0 for 20 cycles → `data_out` stays 1, `busy`=0, `error`=0. Raise `dsr` → start bit on the next cycle, `grant_id`=2.
- `req`=0011, `dsr` dropped during bit 3 of requester 0 → `data_out`=1 next cycle, `error`=1, no `ack`. Restore `dsr` → requester 0 re-granted before 1, `error` clears at grant.
- `rst_n` pulsed low mid-frame → outputs at reset values asynchronously. After release, requester 0 wins first.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg
// Shared definitions for the serial transmit arbiter slice: FSM state
// encoding, frame length and the line levels used for start, stop and idle.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        ABORT = 2'd2
    } tx_state_e;

    // start bit + 8 data bits + stop bit
    localparam int   FRAME_BITS = 10;
    localparam logic START_LVL  = 1'b0;
    localparam logic STOP_LVL   = 1'b1;
    localparam logic IDLE_LVL   = 1'b1;

endpackage

// File: rtl/tx_frame_serializer.sv
// tx_frame_serializer
// Shifts one byte out as start bit, d7..d0, stop bit, each bit held
// BIT_CYCLES clocks. data_out idles high; tx_end pulses during the last
// cycle of the stop bit.
// Ports:
//   clock, rst_n  clock and asynchronous active-low reset
//   load          start a frame with load_byte (ignored while abort is high)
//   load_byte     byte to transmit, sampled on load
//   abort         stop the frame at once and return the line to idle
//   data_out      serial line (registered)
//   tx_end        one-cycle pulse, final stop-bit cycle (registered)
//   end_next      combinational: the next cycle is the final stop-bit cycle
module tx_frame_serializer
    import serial_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 105
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       abort,
    output logic       data_out,
    output logic       tx_end,
    output logic       end_next
);

    localparam int             CW         = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0]  CYC_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0]  CYC_PENULT = CW'(BIT_CYCLES - 2);
    localparam logic [3:0]     BIT_LAST   = 4'(FRAME_BITS - 1);
    localparam logic [3:0]     BIT_STOP   = 4'(FRAME_BITS - 2);

    logic [7:0]    shift_r;
    logic [CW-1:0] cyc_cnt_r;
    logic [3:0]    bit_idx_r;
    logic          active_r;
    logic          data_out_r;
    logic          tx_end_r;
    logic          bit_done_s;
    logic          end_next_s;

    // Decode the end of the current bit and the cycle before the frame's final cycle.
    always_comb begin
        bit_done_s = active_r && (cyc_cnt_r == CYC_LAST);
        end_next_s = active_r && (bit_idx_r == BIT_LAST) && (cyc_cnt_r == CYC_PENULT);
    end

    // Frame sequencing: counters, shift register and registered line outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= 8'h00;
            cyc_cnt_r  <= {CW{1'b0}};
            bit_idx_r  <= 4'd0;
            active_r   <= 1'b0;
            data_out_r <= IDLE_LVL;
            tx_end_r   <= 1'b0;
        end else if (abort) begin
            cyc_cnt_r  <= {CW{1'b0}};
            bit_idx_r  <= 4'd0;
            active_r   <= 1'b0;
            data_out_r <= IDLE_LVL;
            tx_end_r   <= 1'b0;
        end else if (load) begin
            shift_r    <= load_byte;
            cyc_cnt_r  <= {CW{1'b0}};
            bit_idx_r  <= 4'd0;
            active_r   <= 1'b1;
            data_out_r <= START_LVL;
            tx_end_r   <= 1'b0;
        end else if (active_r) begin
            tx_end_r <= end_next_s;
            if (bit_done_s) begin
                cyc_cnt_r <= {CW{1'b0}};
                if (bit_idx_r == BIT_LAST) begin
                    active_r   <= 1'b0;
                    bit_idx_r  <= 4'd0;
                    data_out_r <= IDLE_LVL;
                end else begin
                    bit_idx_r <= bit_idx_r + 4'd1;
                    // Leaving bit 8 (d0) enters the stop bit; earlier bits take the next MSB.
                    if (bit_idx_r == BIT_STOP) begin
                        data_out_r <= STOP_LVL;
                    end else begin
                        data_out_r <= shift_r[7];
                        shift_r    <= {shift_r[6:0], 1'b0};
                    end
                end
            end else begin
                cyc_cnt_r <= cyc_cnt_r + CW'(1);
            end
        end else begin
            tx_end_r <= 1'b0;
        end
    end

    assign data_out = data_out_r;
    assign tx_end   = tx_end_r;
    assign end_next = end_next_s;

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
// Round-robin arbiter sharing one bit-serial byte transmitter among N_REQ
// requesters. Frames are gated by dsr; a dsr drop mid-frame aborts it and
// sets the sticky error flag. The served requester gets a one-cycle ack in
// the final stop-bit cycle.
// Ports:
//   clock, rst_n  clock and asynchronous active-low reset
//   req           level requests, one per requester
//   data_in       byte of requester i on [8i+7:8i], sampled at grant
//   dsr           receiver ready
//   ack           one-hot completion pulse
//   grant_id      requester being served or last served
//   busy          frame in progress
//   data_out      serial line, idles high
//   tx_end        pulse in the final stop-bit cycle
//   error         sticky abort flag, cleared by the next grant
module serial_tx_arbiter
    import serial_tx_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int BIT_CYCLES = 105
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       data_in,
    input  logic                     dsr,
    output logic [N_REQ-1:0]         ack,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     data_out,
    output logic                     tx_end,
    output logic                     error
);

    localparam int               IW       = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    tx_state_e        state_r;
    logic [IW-1:0]    last_r;
    logic [IW-1:0]    grant_id_r;
    logic [N_REQ-1:0] ack_r;
    logic             busy_r;
    logic             error_r;
    logic [IW-1:0]    idx_s;
    logic [IW-1:0]    pick_s;
    logic [7:0]       pick_byte_s;
    logic             found_s;
    logic             load_s;
    logic             abort_s;
    logic             end_next_s;

    // Round-robin search: first set request after last_r, wrapping around.
    always_comb begin
        found_s     = 1'b0;
        idx_s       = {IW{1'b0}};
        pick_s      = {IW{1'b0}};
        pick_byte_s = 8'h00;
        for (int i = 1; i <= N_REQ; i++) begin
            idx_s = IW'((int'(last_r) + i) % N_REQ);
            if (!found_s && req[idx_s]) begin
                found_s     = 1'b1;
                pick_s      = idx_s;
                pick_byte_s = data_in[{idx_s, 3'b000} +: 8];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Serializer control: load on grant, abort on a dsr drop while sending.
    always_comb begin
        load_s  = (state_r == IDLE) && found_s && dsr;
        abort_s = (state_r == SEND) && !dsr;
    end

    // Arbiter FSM with registered ack, grant_id, busy and error.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            last_r     <= IW'(N_REQ - 1);
            grant_id_r <= {IW{1'b0}};
            ack_r      <= {N_REQ{1'b0}};
            busy_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            ack_r <= {N_REQ{1'b0}};
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        state_r    <= SEND;
                        grant_id_r <= pick_s;
                        busy_r     <= 1'b1;
                        error_r    <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEND: begin
                    if (!dsr) begin
                        state_r <= ABORT;
                        busy_r  <= 1'b0;
                        error_r <= 1'b1;
                    end else if (tx_end) begin
                        // final stop-bit cycle just ended
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (end_next_s) begin
                        // ack lines up with the serializer's tx_end cycle
                        ack_r  <= ONE_HOT0 << grant_id_r;
                        last_r <= grant_id_r;
                    end else begin
                        state_r <= SEND;
                    end
                end
                ABORT: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    tx_frame_serializer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_serializer (
        .clock     (clock),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_byte (pick_byte_s),
        .abort     (abort_s),
        .data_out  (data_out),
        .tx_end    (tx_end),
        .end_next  (end_next_s)
    );

    assign ack      = ack_r;
    assign grant_id = grant_id_r;
    assign busy     = busy_r;
    assign error    = error_r;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Testbench for serial_tx_arbiter: timeline reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_serial_tx_arbiter;

    localparam int N_REQ = 4;
    localparam int BC    = 4;
    localparam int FL    = 10 * BC;
    localparam int IW    = $clog2(N_REQ);

    logic                 clock = 1'b0;
    logic                 rst_n;
    logic                 dsr;
    logic [N_REQ-1:0]     req;
    logic [8*N_REQ-1:0]   data_in;
    logic [N_REQ-1:0]     ack;
    logic [IW-1:0]        grant_id;
    logic                 busy, data_out, tx_end, error;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state: phase 0 idle, 1 framing, 2 abort cycle
    int         m_phase, m_el, m_last, m_gid;
    logic [7:0] m_byte;
    logic       m_err;

    logic             dout_log [41];
    logic             txe_log  [41];
    logic             busy_log [41];
    logic [N_REQ-1:0] ack_log  [41];
    logic [IW-1:0]    order    [5];
    int               rise     [5];
    logic [IW-1:0]    exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [9:0]       exp_seq;
    logic [IW-1:0]    gid;
    logic             err_at;
    int               got;
    logic             prev_busy;

    serial_tx_arbiter #(.N_REQ(N_REQ), .BIT_CYCLES(BC)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .req      (req),
        .data_in  (data_in),
        .dsr      (dsr),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .data_out (data_out),
        .tx_end   (tx_end),
        .error    (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic frame_level(input int el, input logic [7:0] b);
        int k = el / BC;
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[8-k];
        else return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_el = 0; m_last = N_REQ - 1; m_gid = 0; m_byte = 8'h00; m_err = 1'b0;
    endtask

    task automatic model_step();
        int p = -1;
        case (m_phase)
            0: begin
                if (dsr)
                    for (int i = 1; i <= N_REQ; i++)
                        if (p < 0 && req[(m_last + i) % N_REQ]) p = (m_last + i) % N_REQ;
                if (p >= 0) begin
                    m_gid = p; m_byte = data_in[8*p +: 8]; m_el = 0; m_phase = 1; m_err = 1'b0;
                end
            end
            1: begin
                if (!dsr) begin
                    m_phase = 2; m_err = 1'b1;
                end else if (m_el == FL - 1) begin
                    m_phase = 0;
                end else begin
                    m_el++;
                    if (m_el == FL - 1) m_last = m_gid;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // Per-cycle comparison against the model, sampled 1 time unit after the edge.
    initial begin
        logic m_txe;
        forever begin
            @(posedge clock);
            if (!rst_n) model_reset(); else model_step();
            #1;
            m_txe = (m_phase == 1) && (m_el == FL - 1);
            chk("busy", 32'(busy), 32'(m_phase == 1));
            chk("data_out", 32'(data_out), 32'((m_phase == 1) ? frame_level(m_el, m_byte) : 1'b1));
            chk("tx_end", 32'(tx_end), 32'(m_txe));
            chk("ack", 32'(ack), m_txe ? (32'd1 << m_gid) : 32'd0);
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("error", 32'(error), 32'(m_err));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, " data_out"}, 32'(data_out), 32'd1);
        chk({tag, " ack"}, 32'(ack), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " tx_end"}, 32'(tx_end), 32'd0);
        chk({tag, " error"}, 32'(error), 32'd0);
        chk({tag, " grant_id"}, 32'(grant_id), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clock); rst_n = 1'b0;
        @(negedge clock); rst_n = 1'b1;
    endtask

    task automatic wait_busy_rise(input string name, output logic [IW-1:0] g, output logic e);
        bit seen = 1'b0;
        g = '0; e = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clock); #1;
            if (busy) begin seen = 1'b1; g = grant_id; e = error; end
        end
        chk({name, " grant seen"}, 32'(seen), 32'd1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clock); #1;
            req = req & ~ack;
            if (req == '0 && !busy) done = 1'b1;
        end
        chk("drain done", 32'(done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; dsr = 1'b1; data_in = '0;
        repeat (3) @(negedge clock);
        #1;
        check_reset_vals("reset");
        @(negedge clock); rst_n = 1'b1;

        // single frame, byte 0xA5 from requester 0
        @(negedge clock); req = 4'b0001; data_in[7:0] = 8'hA5;
        @(posedge clock);
        for (int c = 0; c <= 40; c++) begin
            #1;
            dout_log[c] = data_out; txe_log[c] = tx_end; busy_log[c] = busy; ack_log[c] = ack;
            if (ack != '0) req = '0;
            @(posedge clock);
        end
        exp_seq = 10'b0101001011;
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < BC; j++)
                chk("a5 bit", 32'(dout_log[k*BC+j]), 32'(exp_seq[9-k]));
        chk("a5 tx_end@38", 32'(txe_log[38]), 32'd0);
        chk("a5 tx_end@39", 32'(txe_log[39]), 32'd1);
        chk("a5 ack@38", 32'(ack_log[38]), 32'd0);
        chk("a5 ack@39", 32'(ack_log[39]), 32'd1);
        chk("a5 busy@39", 32'(busy_log[39]), 32'd1);
        chk("a5 busy@40", 32'(busy_log[40]), 32'd0);
        chk("a5 idle line@40", 32'(dout_log[40]), 32'd1);

        // all requesters held: rotation and frame spacing
        pulse_reset();
        @(negedge clock); req = 4'hF; data_in = $urandom;
        got = 0; prev_busy = 1'b0;
        for (int c = 0; c < 300 && got < 5; c++) begin
            @(posedge clock); #1;
            if (busy && !prev_busy) begin order[got] = grant_id; rise[got] = c; got++; end
            prev_busy = busy;
        end
        req = '0;
        chk("rr grant count", 32'(got), 32'd5);
        for (int i = 0; i < 5; i++) chk("rr order", 32'(order[i]), 32'(exp_order[i]));
        for (int i = 1; i < 5; i++) chk("rr spacing", 32'(rise[i] - rise[i-1]), 32'(FL + 1));
        drain();

        // dsr low gates the start
        @(negedge clock); dsr = 1'b0; req = 4'b0100;
        repeat (20) begin
            @(posedge clock); #1;
            chk("dsr0 data_out", 32'(data_out), 32'd1);
            chk("dsr0 busy", 32'(busy), 32'd0);
            chk("dsr0 error", 32'(error), 32'd0);
        end
        @(negedge clock); dsr = 1'b1;
        @(posedge clock); #1;
        chk("dsr1 start bit", 32'(data_out), 32'd0);
        chk("dsr1 grant_id", 32'(grant_id), 32'd2);
        drain();

        // abort during bit 3 of requester 0
        pulse_reset();
        @(negedge clock); req = 4'b0011; data_in = $urandom;
        @(posedge clock);
        repeat (13) @(posedge clock);
        @(negedge clock); dsr = 1'b0;
        @(posedge clock); #1;
        chk("abort data_out", 32'(data_out), 32'd1);
        chk("abort error", 32'(error), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ack", 32'(ack), 32'd0);
        repeat (3) @(negedge clock);
        dsr = 1'b1;
        wait_busy_rise("regrant", gid, err_at);
        chk("regrant id", 32'(gid), 32'd0);
        chk("regrant error clear", 32'(err_at), 32'd0);
        drain();

        // asynchronous reset mid-frame
        @(negedge clock); req = 4'b1000;
        wait_busy_rise("pre-reset", gid, err_at);
        repeat (10) @(posedge clock);
        @(negedge clock); #2; rst_n = 1'b0; #1;
        check_reset_vals("async reset");
        @(negedge clock); rst_n = 1'b1; req = 4'b1001;
        wait_busy_rise("post-reset", gid, err_at);
        chk("post-reset winner", 32'(gid), 32'd0);
        drain();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            req = req & ~ack;
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(0, 499) == 0) req[i] = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) data_in = $urandom;
            if (dsr) begin
                if ($urandom_range(0, 199) == 0) dsr = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                dsr = 1'b1;
            end
        end
        @(negedge clock); dsr = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
